// File: rtl/dest_insert.sv
// Prepends a header beat carrying the packet TID (zero-extended) to an
// AXI4-Stream byte packet; registered output stage with a one-entry skid buffer.
//
// state | meaning
// ------+-------------------------------------------------------------
// HDR   | waiting to emit the header beat for the next packet
// PLD   | forwarding payload beats until the tlast beat is accepted
module dest_insert #(
  parameter int TID_W = 3
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             target_tvalid,
  output logic             target_tready,
  input  logic             target_tlast,
  input  logic [7:0]       target_tdata,
  input  logic [TID_W-1:0] target_tid,
  output logic             initiator_tvalid,
  input  logic             initiator_tready,
  output logic             initiator_tlast,
  output logic [7:0]       initiator_tdata,
  output logic             tid_mismatch
);

  if (TID_W < 1 || TID_W > 8) begin : g_bad_tid_w
    $error("dest_insert: TID_W must be in 1..8");
  end

  localparam logic ST_HDR = 1'b0;
  localparam logic ST_PLD = 1'b1;

  logic             state;
  logic             or_valid;
  logic             or_last;
  logic [7:0]       or_data;
  logic             sk_valid;
  logic             sk_last;
  logic [7:0]       sk_data;
  logic [TID_W-1:0] tid_q;
  logic             mismatch_q;

  logic       or_free;
  logic       accept;
  logic       hdr_load;
  logic [7:0] hdr_byte;

  always_comb begin
    hdr_byte = '0;
    hdr_byte[TID_W-1:0] = target_tid;
  end

  // target_tready depends only on registers, never on initiator_tready
  assign target_tready = (state == ST_PLD) && !sk_valid;
  assign or_free       = !or_valid || initiator_tready;
  assign accept        = target_tvalid && target_tready;
  assign hdr_load      = (state == ST_HDR) && target_tvalid && or_free && !sk_valid;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= ST_HDR;
      or_valid   <= 1'b0;
      or_last    <= 1'b0;
      or_data    <= '0;
      sk_valid   <= 1'b0;
      sk_last    <= 1'b0;
      sk_data    <= '0;
      tid_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      case (state)
        ST_HDR: begin
          if (hdr_load) begin
            state <= ST_PLD;
            tid_q <= target_tid;
          end
        end
        ST_PLD: begin
          if (accept && target_tlast) state <= ST_HDR;
        end
        default: state <= ST_HDR;
      endcase

      // accept implies !sk_valid, so the skid entry always drains first
      if (or_free) begin
        if (sk_valid) begin
          or_valid <= 1'b1;
          or_last  <= sk_last;
          or_data  <= sk_data;
          sk_valid <= 1'b0;
        end else if (hdr_load) begin
          or_valid <= 1'b1;
          or_last  <= 1'b0;
          or_data  <= hdr_byte;
        end else if (accept) begin
          or_valid <= 1'b1;
          or_last  <= target_tlast;
          or_data  <= target_tdata;
        end else begin
          or_valid <= 1'b0;
        end
      end else if (accept) begin
        sk_valid <= 1'b1;
        sk_last  <= target_tlast;
        sk_data  <= target_tdata;
      end

      mismatch_q <= accept && (target_tid != tid_q);
    end
  end

  assign initiator_tvalid = or_valid;
  assign initiator_tlast  = or_last;
  assign initiator_tdata  = or_data;
  assign tid_mismatch     = mismatch_q;

endmodule
